// File: rtl/fifo_arbiter_pkg.sv
// Shared encodings for the two-requester FT2232H byte-port arbiter.
package fifo_arbiter_pkg;

    localparam logic OP_TX = 1'b0;
    localparam logic OP_RX = 1'b1;

    localparam logic REQ_AUDIO = 1'b0;
    localparam logic REQ_CTRL  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } arb_state_e;

    function automatic logic [1:0] req_onehot(input logic idx);
        return (idx == REQ_CTRL) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fifo_arbiter_rr.sv
// Combinational two-way round-robin pick; a held lock masks the other requester out.
module rr_arbiter2
    import fifo_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_ptr,
    input  logic       lock_valid,
    input  logic       lock_owner,
    output logic [1:0] grant
);

    logic [1:0] cand;

    // rr_ptr names the last requester served, so a tie goes to the other one.
    always_comb begin
        cand  = lock_valid ? (req & req_onehot(lock_owner)) : req;
        grant = cand;
        if (cand == 2'b11) begin
            grant = req_onehot(~rr_ptr);
        end
    end

endmodule

// File: rtl/fifo_arbiter.sv
// Serialises audio and control byte transactions onto the single fifo_interface port,
// with per-owner locking for multi-byte packets and a watchdog on unanswered requests.
module fifo_arbiter
    import fifo_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [1:0]  req_i,
    input  logic [1:0]  op_i,
    input  logic [1:0]  lock_i,
    input  logic [15:0] tx_data_i,
    output logic [1:0]  accept_o,
    output logic [1:0]  done_o,
    output logic        ok_o,
    output logic [7:0]  rx_data_o,
    output logic        timeout_o,
    output logic        fifo_tx_data_rdy_o,
    output logic [7:0]  fifo_tx_data_o,
    output logic        fifo_rx_poll_o,
    input  logic        fifo_tx_ok_i,
    input  logic        fifo_tx_err_i,
    input  logic        fifo_rx_data_rdy_i,
    input  logic [7:0]  fifo_rx_data_i,
    input  logic        fifo_rx_err_i,
    input  logic        fifo_busy_i
);

    localparam int             WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_e state, state_next;

    logic            owner;
    logic            cap_op;
    logic            cap_lock;
    logic [7:0]      tx_byte;
    logic            lock_valid;
    logic            lock_owner;
    logic            rr_ptr;
    logic [WD_W-1:0] wd_cnt;
    logic            ok_q;
    logic            timeout_q;
    logic [7:0]      rx_data_q;
    logic            tx_rdy_q;
    logic            rx_poll_q;

    logic [1:0] grant;
    logic       gnt_idx;
    logic       accepted;
    logic       issue;
    logic       finish;
    logic       finish_ok;
    logic       wd_fire;

    rr_arbiter2 u_rr (
        .req        (req_i),
        .rr_ptr     (rr_ptr),
        .lock_valid (lock_valid),
        .lock_owner (lock_owner),
        .grant      (grant)
    );

    assign gnt_idx = grant[1];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Errors beat successes, and any real response beats the watchdog.
    always_comb begin
        state_next = state;
        accepted   = 1'b0;
        issue      = 1'b0;
        finish     = 1'b0;
        finish_ok  = 1'b0;
        wd_fire    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    accepted   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!fifo_busy_i) begin
                    issue      = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cap_op == OP_TX) begin
                    if (fifo_tx_err_i) begin
                        finish = 1'b1;
                    end else if (fifo_tx_ok_i) begin
                        finish    = 1'b1;
                        finish_ok = 1'b1;
                    end
                end else begin
                    if (fifo_rx_err_i) begin
                        finish = 1'b1;
                    end else if (fifo_rx_data_rdy_i) begin
                        finish    = 1'b1;
                        finish_ok = 1'b1;
                    end
                end
                if (!finish && wd_cnt >= WD_LAST) begin
                    finish  = 1'b1;
                    wd_fire = 1'b1;
                end
                if (finish) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            owner      <= 1'b0;
            cap_op     <= OP_TX;
            cap_lock   <= 1'b0;
            tx_byte    <= 8'h00;
            lock_valid <= 1'b0;
            lock_owner <= 1'b0;
            rr_ptr     <= 1'b1;
            wd_cnt     <= '0;
            ok_q       <= 1'b0;
            timeout_q  <= 1'b0;
            rx_data_q  <= 8'h00;
            tx_rdy_q   <= 1'b0;
            rx_poll_q  <= 1'b0;
        end else begin
            if (accepted) begin
                owner    <= gnt_idx;
                cap_op   <= op_i[gnt_idx];
                cap_lock <= lock_i[gnt_idx];
                tx_byte  <= gnt_idx ? tx_data_i[15:8] : tx_data_i[7:0];
                rr_ptr   <= gnt_idx;
            end
            tx_rdy_q  <= issue && (cap_op == OP_TX);
            rx_poll_q <= issue && (cap_op == OP_RX);
            if (issue) begin
                wd_cnt <= '0;
            end else if (state == ST_WAIT && wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (finish) begin
                ok_q      <= finish_ok;
                timeout_q <= wd_fire;
                if (finish_ok && cap_op == OP_RX) begin
                    rx_data_q <= fifo_rx_data_i;
                end
            end
            // A failed or timed-out transaction never keeps the port locked.
            if (state == ST_DONE) begin
                lock_valid <= cap_lock && ok_q;
                lock_owner <= owner;
            end
        end
    end

    assign accept_o           = (state == ST_IDLE && reset_ni) ? grant : 2'b00;
    assign done_o             = (state == ST_DONE) ? req_onehot(owner) : 2'b00;
    assign ok_o               = (state == ST_DONE) && ok_q;
    assign timeout_o          = (state == ST_DONE) && timeout_q;
    assign rx_data_o          = rx_data_q;
    assign fifo_tx_data_rdy_o = tx_rdy_q;
    assign fifo_rx_poll_o     = rx_poll_q;
    assign fifo_tx_data_o     = (state == ST_ISSUE || state == ST_WAIT) ? tx_byte : 8'h00;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter: a small fifo_interface responder plus a completion scoreboard.
module tb_fifo_arbiter;

    localparam int RSP_NONE    = 0;
    localparam int RSP_TX_OK   = 1;
    localparam int RSP_TX_BOTH = 2;
    localparam int RSP_RX_DATA = 3;
    localparam int RSP_RX_ERR  = 4;

    typedef struct packed {
        logic [1:0] done;
        logic       ok;
        logic       to;
        logic       chk_rx;
        logic [7:0] rx;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req;
    logic [1:0]  op;
    logic [1:0]  lock;
    logic [15:0] tx_data;
    logic [1:0]  accept_o;
    logic [1:0]  done_o;
    logic        ok_o;
    logic [7:0]  rx_data_o;
    logic        timeout_o;
    logic        fifo_tx_data_rdy_o;
    logic [7:0]  fifo_tx_data_o;
    logic        fifo_rx_poll_o;
    logic        fifo_tx_ok;
    logic        fifo_tx_err;
    logic        fifo_rx_data_rdy;
    logic [7:0]  fifo_rx_data;
    logic        fifo_rx_err;
    logic        fifo_busy;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    int         resp_kind = RSP_TX_OK;
    int         resp_delay = 2;
    logic [7:0] resp_rx_byte = 8'h00;
    int         pulse_count = 0;
    logic [7:0] last_tx = 8'h00;
    int         rsp_cnt = 0;
    bit         rsp_pending = 1'b0;

    always #5 clk = ~clk;

    fifo_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i              (clk),
        .reset_ni           (reset_n),
        .req_i              (req),
        .op_i               (op),
        .lock_i             (lock),
        .tx_data_i          (tx_data),
        .accept_o           (accept_o),
        .done_o             (done_o),
        .ok_o               (ok_o),
        .rx_data_o          (rx_data_o),
        .timeout_o          (timeout_o),
        .fifo_tx_data_rdy_o (fifo_tx_data_rdy_o),
        .fifo_tx_data_o     (fifo_tx_data_o),
        .fifo_rx_poll_o     (fifo_rx_poll_o),
        .fifo_tx_ok_i       (fifo_tx_ok),
        .fifo_tx_err_i      (fifo_tx_err),
        .fifo_rx_data_rdy_i (fifo_rx_data_rdy),
        .fifo_rx_data_i     (fifo_rx_data),
        .fifo_rx_err_i      (fifo_rx_err),
        .fifo_busy_i        (fifo_busy)
    );

    // Responder: answers each request pulse resp_delay cycles later with a one-cycle response.
    initial begin
        fifo_tx_ok       = 1'b0;
        fifo_tx_err      = 1'b0;
        fifo_rx_data_rdy = 1'b0;
        fifo_rx_err      = 1'b0;
        fifo_rx_data     = 8'h00;
        forever begin
            @(negedge clk);
            fifo_tx_ok       = 1'b0;
            fifo_tx_err      = 1'b0;
            fifo_rx_data_rdy = 1'b0;
            fifo_rx_err      = 1'b0;
            fifo_rx_data     = resp_rx_byte;
            if (!reset_n) begin
                rsp_pending = 1'b0;
            end else begin
                if (rsp_pending) begin
                    rsp_cnt = rsp_cnt - 1;
                    if (rsp_cnt <= 0) begin
                        rsp_pending = 1'b0;
                        case (resp_kind)
                            RSP_TX_OK:   fifo_tx_ok = 1'b1;
                            RSP_TX_BOTH: begin fifo_tx_ok = 1'b1; fifo_tx_err = 1'b1; end
                            RSP_RX_DATA: fifo_rx_data_rdy = 1'b1;
                            RSP_RX_ERR:  begin fifo_rx_err = 1'b1; fifo_rx_data_rdy = 1'b1; end
                            default:     ;
                        endcase
                    end
                end
                if (fifo_tx_data_rdy_o || fifo_rx_poll_o) begin
                    pulse_count = pulse_count + 1;
                    if (fifo_tx_data_rdy_o) last_tx = fifo_tx_data_o;
                    rsp_pending = 1'b1;
                    rsp_cnt     = resp_delay;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] o, input logic [1:0] l,
                                 input logic [15:0] t);
        req     = r;
        op      = o;
        lock    = l;
        tx_data = t;
    endtask

    task automatic pushExp(input logic [1:0] d, input logic k, input logic to, input logic chk,
                           input logic [7:0] rx);
        exp_t e;
        e.done   = d;
        e.ok     = k;
        e.to     = to;
        e.chk_rx = chk;
        e.rx     = rx;
        exp_q.push_back(e);
    endtask

    // Returns just after the accept edge, so the caller may change that requester's inputs.
    task automatic waitAccept(input string tag, input int n, input int budget);
        int cyc;
        cyc = 0;
        #1;
        while (accept_o == 2'b00 && cyc < budget) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        checkOutput(tag, 16'(accept_o), 16'(1 << n));
        if (accept_o != 2'b00) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDone(input string tag, input int budget, output int cyc);
        exp_t e;
        cyc = 0;
        while (done_o == 2'b00 && cyc < budget) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        checkOutput({tag, "_seen"}, 16'(done_o != 2'b00), 16'h1);
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 16'(done_o), 16'h0);
        end else begin
            e = exp_q.pop_front();
            checkOutput({tag, "_done"}, 16'(done_o), 16'(e.done));
            checkOutput({tag, "_ok"}, 16'(ok_o), 16'(e.ok));
            checkOutput({tag, "_timeout"}, 16'(timeout_o), 16'(e.to));
            if (e.chk_rx) checkOutput({tag, "_rx"}, 16'(rx_data_o), 16'(e.rx));
        end
    endtask

    initial begin
        int  cyc;
        int  pulses_before;
        logic any_done;

        reset_n   = 1'b0;
        fifo_busy = 1'b0;
        applyStimulus(2'b11, 2'b00, 2'b00, 16'h3CA5);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_ctrl_outs",
                    16'({accept_o, done_o, ok_o, timeout_o, fifo_tx_data_rdy_o, fifo_rx_poll_o}), 16'h0);
        checkOutput("rst_data_outs", {rx_data_o, fifo_tx_data_o}, 16'h0000);

        // Both requesters at reset release: audio wins the first tie, control follows.
        @(negedge clk);
        reset_n = 1'b1;
        pushExp(2'b01, 1'b1, 1'b0, 1'b0, 8'h00);
        pushExp(2'b10, 1'b1, 1'b0, 1'b0, 8'h00);
        waitAccept("tie_acc0", 0, 5);
        applyStimulus(2'b10, 2'b00, 2'b00, 16'h3CA5);
        waitDone("tie_done0", 20, cyc);
        checkOutput("tie_byte0", 16'(last_tx), 16'h00A5);
        waitAccept("tie_acc1", 1, 5);
        applyStimulus(2'b00, 2'b00, 2'b00, 16'h0000);
        waitDone("tie_done1", 20, cyc);
        checkOutput("tie_byte1", 16'(last_tx), 16'h003C);

        // Locked packet from audio keeps control waiting.
        applyStimulus(2'b11, 2'b00, 2'b01, 16'h1181);
        pushExp(2'b01, 1'b1, 1'b0, 1'b0, 8'h00);
        pushExp(2'b01, 1'b1, 1'b0, 1'b0, 8'h00);
        pushExp(2'b10, 1'b1, 1'b0, 1'b0, 8'h00);
        waitAccept("lock_acc0", 0, 5);
        applyStimulus(2'b11, 2'b00, 2'b00, 16'h1105);
        waitDone("lock_done0", 20, cyc);
        checkOutput("lock_byte0", 16'(last_tx), 16'h0081);
        waitAccept("lock_acc0b", 0, 5);
        applyStimulus(2'b10, 2'b00, 2'b00, 16'h1105);
        waitDone("lock_done0b", 20, cyc);
        checkOutput("lock_byte0b", 16'(last_tx), 16'h0005);
        waitAccept("lock_acc1", 1, 5);
        applyStimulus(2'b00, 2'b00, 2'b00, 16'h0000);
        waitDone("lock_done1", 20, cyc);
        checkOutput("lock_byte1", 16'(last_tx), 16'h0011);

        // RX poll from control with the minimum response latency.
        resp_kind    = RSP_RX_DATA;
        resp_delay   = 1;
        resp_rx_byte = 8'h7E;
        applyStimulus(2'b10, 2'b10, 2'b00, 16'h0000);
        pushExp(2'b10, 1'b1, 1'b0, 1'b1, 8'h7E);
        waitAccept("rx_acc", 1, 5);
        applyStimulus(2'b00, 2'b00, 2'b00, 16'h0000);
        waitDone("rx_done", 20, cyc);
        checkOutput("rx_turnaround", 16'(cyc), 16'd4);
        @(negedge clk);
        #1;
        checkOutput("done_pulse_width", 16'(done_o), 16'h0);

        // Errors report ok=0 and drop the lock.
        resp_kind  = RSP_TX_BOTH;
        resp_delay = 2;
        resp_rx_byte = 8'hC3;
        applyStimulus(2'b01, 2'b00, 2'b01, 16'h0042);
        pushExp(2'b01, 1'b0, 1'b0, 1'b0, 8'h00);
        waitAccept("err_acc0", 0, 5);
        applyStimulus(2'b11, 2'b01, 2'b01, 16'h9900);
        waitDone("err_tx_done", 20, cyc);
        resp_kind = RSP_TX_OK;
        pushExp(2'b10, 1'b1, 1'b0, 1'b0, 8'h00);
        waitAccept("err_unlock_acc1", 1, 5);
        applyStimulus(2'b01, 2'b01, 2'b01, 16'h0000);
        waitDone("err_ctrl_done", 20, cyc);
        waitAccept("err_rx_acc0", 0, 5);
        resp_kind = RSP_RX_ERR;
        pushExp(2'b01, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(2'b00, 2'b00, 2'b00, 16'h0000);
        waitDone("err_rx_done", 20, cyc);
        checkOutput("err_rx_no_latch", 16'(rx_data_o), 16'h007E);
        resp_kind = RSP_TX_OK;
        applyStimulus(2'b10, 2'b00, 2'b00, 16'h6600);
        pushExp(2'b10, 1'b1, 1'b0, 1'b0, 8'h00);
        waitAccept("err_rx_unlock_acc1", 1, 5);
        applyStimulus(2'b00, 2'b00, 2'b00, 16'h0000);
        waitDone("err_rx_unlock_done", 20, cyc);

        // Busy holds the request pulse back, then exactly one pulse goes out.
        resp_delay = 1;
        fifo_busy  = 1'b1;
        pulses_before = pulse_count;
        applyStimulus(2'b01, 2'b00, 2'b00, 16'h005A);
        pushExp(2'b01, 1'b1, 1'b0, 1'b0, 8'h00);
        waitAccept("busy_acc", 0, 5);
        applyStimulus(2'b00, 2'b00, 2'b00, 16'h0000);
        repeat (10) begin
            @(negedge clk);
            #1;
        end
        checkOutput("busy_no_pulse", 16'(pulse_count - pulses_before), 16'd0);
        fifo_busy = 1'b0;
        waitDone("busy_done", 20, cyc);
        checkOutput("busy_one_pulse", 16'(pulse_count - pulses_before), 16'd1);
        checkOutput("busy_byte", 16'(last_tx), 16'h005A);

        // Unanswered request: watchdog fires after 16 WAIT cycles.
        resp_kind = RSP_NONE;
        applyStimulus(2'b10, 2'b00, 2'b00, 16'h7700);
        pushExp(2'b10, 1'b0, 1'b1, 1'b0, 8'h00);
        waitAccept("wd_acc", 1, 5);
        applyStimulus(2'b00, 2'b00, 2'b00, 16'h0000);
        waitDone("wd_done", 40, cyc);
        checkOutput("wd_latency", 16'(cyc), 16'd18);

        // Reset in the middle of WAIT clears everything with no completion.
        applyStimulus(2'b01, 2'b00, 2'b01, 16'h0033);
        waitAccept("mid_rst_acc", 0, 5);
        applyStimulus(2'b00, 2'b00, 2'b00, 16'h0000);
        repeat (5) begin
            @(negedge clk);
            #1;
        end
        checkOutput("mid_rst_txdata", 16'(fifo_tx_data_o), 16'h0033);
        checkOutput("mid_rst_rx_before", 16'(rx_data_o), 16'h007E);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_ctrl_outs",
                    16'({accept_o, done_o, ok_o, timeout_o, fifo_tx_data_rdy_o, fifo_rx_poll_o}), 16'h0);
        checkOutput("mid_rst_data_outs", {rx_data_o, fifo_tx_data_o}, 16'h0000);
        @(negedge clk);
        reset_n  = 1'b1;
        any_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (done_o != 2'b00 || timeout_o) any_done = 1'b1;
        end
        checkOutput("mid_rst_no_done", 16'(any_done), 16'h0);
        checkOutput("sb_drained", 16'(exp_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_arbiter.md
# fifo_arbiter

Shares the single FT2232H byte-transfer port of `fifo_interface` between two requesters: requester 0 is the audio sample streamer and requester 1 is the control/status channel. Each requester issues one byte transaction at a time, either a TX byte or an RX poll. The arbiter serialises these transactions, forwards them to `fifo_interface`, and returns completion status and RX data to the owning requester. A per-transaction lock keeps multi-byte packets from interleaving, and a watchdog aborts transactions that `fifo_interface` never answers.

## Interface
- `TIMEOUT_CYCLES`, default 4096: maximum number of WAIT cycles before a transaction is aborted.
- `clk_i`  in  1  system clock.
- `reset_ni`  in  1  reset, asynchronous, active-low.
- `req_i`  in  2  per-requester transaction request, held until accepted.
- `op_i`  in  2  per-requester operation: 0 = TX, 1 = RX poll.
- `lock_i`  in  2  per-requester lock: keep ownership after this transaction.
- `tx_data_i`  in  16  TX bytes; requester n drives bits [8n+7:8n].
- `accept_o`  out  2  one-hot; transfer occurs when `req_i[n] & accept_o[n]`.
- `done_o`  out  2  one-cycle completion pulse to the owning requester.
- `ok_o`  out  1  completion status, valid while any `done_o` bit is high.
- `rx_data_o`  out  8  received byte, valid with `done_o` when `ok_o` is high.
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires.
- `fifo_tx_data_rdy_o`, `fifo_tx_data_o[7:0]`, `fifo_rx_poll_o`  out  drive the `fifo_interface` request inputs.
- `fifo_tx_ok_i`, `fifo_tx_err_i`, `fifo_rx_data_rdy_i`, `fifo_rx_data_i[7:0]`, `fifo_rx_err_i`, `fifo_busy_i`  in  `fifo_interface` responses.

## Operation
- **States:** IDLE, ISSUE, WAIT, DONE.
- **IDLE arbitration:**
  - Candidate set is `req_i`, masked to the lock owner alone while a lock is held.
  - With two candidates, grant the requester that was not granted last (round-robin).
  - `accept_o` is combinational and asserted in IDLE only.
  - On the accept edge, capture owner, op, lock and tx byte, then go to ISSUE.
- **ISSUE:**
  - While `fifo_busy_i` is high, stay in ISSUE.
  - Otherwise pulse `fifo_tx_data_rdy_o` (TX) or `fifo_rx_poll_o` (RX) for exactly one cycle, clear the watchdog, and go to WAIT.
  - `fifo_tx_data_o` holds the captured byte from ISSUE through WAIT.
- **WAIT, TX:**
  - `fifo_tx_err_i` gives ok = 0.
  - `fifo_tx_ok_i` alone gives ok = 1.
  - Error wins if both are asserted in the same cycle.
- **WAIT, RX:**
  - `fifo_rx_err_i` gives ok = 0.
  - `fifo_rx_data_rdy_i` alone gives ok = 1 and latches `fifo_rx_data_i`.
  - Error wins if both are asserted in the same cycle.
- **Ignored responses:** responses of the other op type, and any response outside WAIT, are ignored.
- **Watchdog:** the counter increments every WAIT cycle. When it reaches `TIMEOUT_CYCLES`, go to DONE with ok = 0 and pulse `timeout_o` in that same cycle.
- **DONE:**
  - Assert `done_o[owner]` and `ok_o`.
  - Update the lock: it stays held only if the captured lock bit is 1 and ok = 1. An error or timeout always releases the lock.
  - Go to IDLE.
- **Arithmetic:** the watchdog counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide and saturates at its terminal value.
- **Reset values:**
  - All outputs are 0.
  - State is IDLE, no lock is held, and the round-robin pointer is 1, so requester 0 wins the first tie.
  - The watchdog counter and the rx_data latch are 0.
- **Reset mid-operation:** asynchronous clear to the reset values. No completion pulse is produced; requesters must re-issue.

## Timing
- Accept edge at cycle t gives the fifo request pulse at t+1 (if `fifo_busy_i` is low), otherwise at the first non-busy cycle.
- A response at cycle r gives `done_o` at r+1.
- A new accept is possible at the cycle after `done_o`.
- Minimum turnaround, accept to done, is 4 cycles when the response arrives one cycle after the request pulse.
- A requester holding `req_i` through its own `done_o` is re-accepted in the next IDLE cycle.
- A locked owner gets back-to-back service with one IDLE cycle between transactions. The other requester waits until the lock is released.
- The fifo request pulses are registered, so there is no combinational path from `fifo_*_i` to `fifo_*_o`.

## Structure
- **Shared constants header:**
  - op encodings `OP_TX`/`OP_RX`.
  - requester indices `REQ_AUDIO = 0`, `REQ_CTRL = 1`.
  - state encodings.
- **Sub-module:** `rr_arbiter2`, a combinational two-way round-robin pick with lock masking. It outputs a one-hot grant from `req`, the round-robin pointer, lock-valid and lock-owner.

## Test plan
- Both requesters TX-request at reset release (0xA5 from 0, 0x3C from 1), fifo answers tx_ok after 2 cycles → 0xA5 is sent first, then 0x3C; `done_o` = 01 then 10, `ok_o` = 1 both times.
- Requester 0 locks a TX 0x81 while requester 1 requests continuously → requester 0's next byte 0x05 is granted before requester 1; requester 1 is served only after requester 0 completes with lock = 0.
- RX poll from requester 1, fifo returns rx_data_rdy with 0x7E → `done_o` = 10, `ok_o` = 1, `rx_data_o` = 0x7E.
- TX with tx_ok and tx_err asserted together, then an RX answered with rx_err → both completions report `ok_o` = 0, and any held lock is released.
- `fifo_busy_i` high for 10 cycles after accept → no request pulse until busy drops, then exactly one pulse.
- Fifo never responds with `TIMEOUT_CYCLES` = 16 → `timeout_o` and `done_o` assert after 16 WAIT cycles with `ok_o` = 0. A reset asserted mid-WAIT instead returns all outputs to 0 immediately.
